// File: rtl/semaforo_n_if.sv
// Lamp/sensor bundle for the N-street traffic-light controller.
// The controller takes the slave modport; the environment driving sensors takes the master modport.
interface semaforo_n_if #(
  parameter int N_RUAS = 3
);
  localparam int AW = (N_RUAS > 1) ? $clog2(N_RUAS) : 1;

  // pulso: a single-clock strobe with no ready side. demanda and modo_noturno are level inputs.
  // The lamps, rua_ativa and estado are registered and may be sampled at any point away from the edge.
  logic              pulso;
  logic [N_RUAS-1:0] demanda;
  logic              modo_noturno;
  logic [N_RUAS-1:0] verde;
  logic [N_RUAS-1:0] amarelo;
  logic [N_RUAS-1:0] vermelho;
  logic [AW-1:0]     rua_ativa;
  logic [1:0]        estado;

  modport master (
    output pulso, demanda, modo_noturno,
    input  verde, amarelo, vermelho, rua_ativa, estado
  );

  modport slave (
    input  pulso, demanda, modo_noturno,
    output verde, amarelo, vermelho, rua_ativa, estado
  );
endinterface

// File: rtl/semaforo_n.sv
// N-street round-robin traffic-light controller with demand skipping and a blinking night mode.
// All timing advances on pulso ticks. Every lamp is registered in the single FSM process.
module semaforo_n #(
  parameter int N_RUAS     = 3,
  parameter int T_VERDE    = 4,
  parameter int T_AMARELO  = 2,
  parameter int T_VERMELHO = 1,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  semaforo_n_if.slave ctl_io
);
  localparam int AW = (N_RUAS > 1) ? $clog2(N_RUAS) : 1;
  localparam logic [N_RUAS-1:0] UM     = N_RUAS'(1);
  localparam logic [CNT_W-1:0]  FIM_V  = CNT_W'(T_VERDE - 1);
  localparam logic [CNT_W-1:0]  FIM_A  = CNT_W'(T_AMARELO - 1);
  localparam logic [CNT_W-1:0]  FIM_VM = CNT_W'(T_VERMELHO - 1);

  typedef enum logic [1:0] {
    VERDE    = 2'd0,
    AMARELO  = 2'd1,
    TODOS_VM = 2'd2,
    NOTURNO  = 2'd3
  } estado_t;

  estado_t           state_q;
  logic [AW-1:0]     a_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pisca_q;
  logic [N_RUAS-1:0] verde_q;
  logic [N_RUAS-1:0] amarelo_q;
  logic [N_RUAS-1:0] vermelho_q;

  logic [AW-1:0]     prox_d;
  logic              outra;
  int                idx;

  function automatic logic [N_RUAS-1:0] um_hot(input logic [AW-1:0] i);
    um_hot = UM << i;
  endfunction

  assign outra = |(ctl_io.demanda & ~um_hot(a_q));

  // Next owner of green: scan from a+1 upward, wrapping. The loop runs backwards so the nearest hit wins.
  always_comb begin
    prox_d = (a_q == AW'(N_RUAS - 1)) ? '0 : a_q + 1'b1;
    idx    = 0;
    if (ctl_io.demanda != '0) begin
      for (int k = N_RUAS; k >= 1; k--) begin
        idx = int'(a_q) + k;
        if (idx >= N_RUAS) idx = idx - N_RUAS;
        if (ctl_io.demanda[idx[AW-1:0]]) prox_d = idx[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= VERDE;
      a_q        <= '0;
      cnt_q      <= '0;
      pisca_q    <= 1'b0;
      verde_q    <= UM;
      amarelo_q  <= '0;
      vermelho_q <= ~UM;
    end else if (ctl_io.modo_noturno) begin
      if (state_q != NOTURNO) begin
        state_q    <= NOTURNO;
        cnt_q      <= '0;
        pisca_q    <= 1'b1;
        verde_q    <= '0;
        vermelho_q <= '0;
        amarelo_q  <= '1;
      end else if (ctl_io.pulso) begin
        pisca_q   <= ~pisca_q;
        amarelo_q <= {N_RUAS{~pisca_q}};
      end
    end else begin
      case (state_q)
        NOTURNO: begin
          state_q    <= TODOS_VM;
          cnt_q      <= '0;
          verde_q    <= '0;
          amarelo_q  <= '0;
          vermelho_q <= '1;
        end
        VERDE: if (ctl_io.pulso) begin
          if (cnt_q == FIM_V) begin
            // Green is held, with cnt saturated, while only this street is asking.
            if (ctl_io.demanda == '0 || outra) begin
              state_q    <= AMARELO;
              cnt_q      <= '0;
              verde_q    <= '0;
              amarelo_q  <= um_hot(a_q);
              vermelho_q <= ~um_hot(a_q);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        AMARELO: if (ctl_io.pulso) begin
          if (cnt_q == FIM_A) begin
            state_q    <= TODOS_VM;
            cnt_q      <= '0;
            amarelo_q  <= '0;
            vermelho_q <= '1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: if (ctl_io.pulso) begin
          if (cnt_q == FIM_VM) begin
            state_q    <= VERDE;
            cnt_q      <= '0;
            a_q        <= prox_d;
            verde_q    <= um_hot(prox_d);
            vermelho_q <= ~um_hot(prox_d);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign ctl_io.verde     = verde_q;
  assign ctl_io.amarelo   = amarelo_q;
  assign ctl_io.vermelho  = vermelho_q;
  assign ctl_io.rua_ativa = a_q;
  assign ctl_io.estado    = state_q;
endmodule

// File: tb/tb_semaforo_n.sv
// Directed bench for semaforo_n with 3 streets, T_VERDE=3, T_AMARELO=2 and T_VERMELHO=1.
// pulso fires one clock in every eleven clocks.
module tb_semaforo_n;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic inv_on = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  semaforo_n_if #(.N_RUAS(3)) sif ();

  semaforo_n #(
    .N_RUAS(3), .T_VERDE(3), .T_AMARELO(2), .T_VERMELHO(1), .CNT_W(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl_io (sif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // The packed word is {rua_ativa[1:0], verde[2:0], amarelo[2:0], vermelho[2:0]}.
  function automatic logic [31:0] pk(input int rua, input logic [2:0] v, input logic [2:0] y,
                                     input logic [2:0] r);
    logic [1:0] ru;
    ru = rua[1:0];
    pk = {21'd0, ru, v, y, r};
  endfunction

  function automatic logic [31:0] obs_w();
    obs_w = {21'd0, sif.rua_ativa, sif.verde, sif.amarelo, sif.vermelho};
  endfunction

  function automatic logic [31:0] grn(input int s);
    logic [2:0] g;
    g = 3'b001 << s;
    grn = pk(s, g, 3'b000, ~g);
  endfunction

  function automatic logic [31:0] ylw(input int s);
    logic [2:0] g;
    g = 3'b001 << s;
    ylw = pk(s, 3'b000, g, ~g);
  endfunction

  task automatic tick();
    repeat (10) @(negedge clk);
    sif.pulso = 1'b1;
    @(negedge clk);
    sif.pulso = 1'b0;
  endtask

  task automatic tick_chk(input string tag, input logic [31:0] exp);
    tick();
    check(tag, obs_w(), exp);
  endtask

  task automatic do_reset(input logic [2:0] dem);
    sif.demanda = dem;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      check("inv", {31'd0, ((sif.verde | sif.amarelo | sif.vermelho) == 3'b111) &&
                   (((sif.verde & sif.amarelo) | (sif.verde & sif.vermelho) |
                     (sif.amarelo & sif.vermelho)) == 3'b000)}, 32'd1);
    end
  end

  initial begin
    sif.pulso        = 1'b0;
    sif.modo_noturno = 1'b0;
    do_reset(3'b000);
    inv_on = 1'b1;

    // 1: fixed-time rotation R0 -> R1 -> R2 -> R0
    check("rst_lamps", obs_w(), grn(0));
    for (int s = 0; s < 3; s++) begin
      exp_q.push_back(grn(s));
      exp_q.push_back(grn(s));
      exp_q.push_back(ylw(s));
      exp_q.push_back(ylw(s));
      exp_q.push_back(pk(s, 3'b000, 3'b000, 3'b111));
      exp_q.push_back(grn((s + 1) % 3));
    end
    while (exp_q.size() > 0) tick_chk("rot", exp_q.pop_front());

    // 2: a long run with no pulso changes nothing, and the count resumes where it was
    tick_chk("pre_idle", grn(0));
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("idle", obs_w(), grn(0));
    end
    tick_chk("post_idle_g", grn(0));
    tick_chk("post_idle_y", ylw(0));

    // 3: demand only on R2 skips R1, then holds R2 green
    do_reset(3'b100);
    check("rst2", obs_w(), grn(0));
    tick_chk("d_g1", grn(0));
    tick_chk("d_g2", grn(0));
    tick_chk("d_y1", ylw(0));
    tick_chk("d_y2", ylw(0));
    tick_chk("d_red", pk(0, 3'b000, 3'b000, 3'b111));
    tick_chk("d_r2", grn(2));
    for (int i = 0; i < 8; i++) tick_chk("hold_r2", grn(2));

    // 4: new demand on R1 releases the held green, and the search wraps past R0
    sif.demanda = 3'b110;
    tick_chk("rel_y", ylw(2));
    tick_chk("rel_y2", ylw(2));
    tick_chk("rel_red", pk(2, 3'b000, 3'b000, 3'b111));
    tick_chk("wrap_r1", grn(1));

    // 5: night mode entered in the middle of AMARELO
    tick_chk("n_g", grn(1));
    tick_chk("n_g2", grn(1));
    tick_chk("n_y", ylw(1));
    inv_on = 1'b0;
    sif.modo_noturno = 1'b1;
    @(negedge clk);
    check("night_on", obs_w(), pk(1, 3'b000, 3'b111, 3'b000));
    repeat (15) @(negedge clk);
    check("night_nopulse", obs_w(), pk(1, 3'b000, 3'b111, 3'b000));
    tick_chk("blink0", pk(1, 3'b000, 3'b000, 3'b000));
    tick_chk("blink1", pk(1, 3'b000, 3'b111, 3'b000));
    tick_chk("blink2", pk(1, 3'b000, 3'b000, 3'b000));
    sif.modo_noturno = 1'b0;
    @(negedge clk);
    check("night_off", obs_w(), pk(1, 3'b000, 3'b000, 3'b111));
    inv_on = 1'b1;
    tick_chk("after_night", grn(2));

    // 6: asynchronous reset in the middle of R1 green
    sif.demanda = 3'b000;
    tick_chk("r6_g", grn(2));
    tick_chk("r6_g2", grn(2));
    tick_chk("r6_y", ylw(2));
    tick_chk("r6_y2", ylw(2));
    tick_chk("r6_red", pk(2, 3'b000, 3'b000, 3'b111));
    tick_chk("r6_r0", grn(0));
    repeat (5) tick();
    tick_chk("r6_r1", grn(1));
    tick_chk("r6_mid", grn(1));
    #2 rst = 1'b1;
    #1 check("async_rst", obs_w(), grn(0));
    @(negedge clk);
    rst = 1'b0;
    check("post_rst", obs_w(), grn(0));
    tick_chk("pr_g", grn(0));
    tick_chk("pr_g2", grn(0));
    tick_chk("pr_y", ylw(0));
    tick();
    tick();
    tick_chk("pr_r1", grn(1));

    inv_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
